// File: rtl/scope_pkg.sv
// Shared state encoding and default geometry for the scope capture sequencer.
package scope_pkg;

  localparam int SCOPE_DEPTH   = 640;
  localparam int SCOPE_AW      = 10;
  localparam int SCOPE_HOLDOFF = 1000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    SHOW    = 2'd3
  } scope_state_t;

  function automatic logic is_busy(input scope_state_t s);
    return (s == ARMED) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Counts enabled cycles from 0; done is high on the cycle the count reaches HOLDOFF-1.
module holdoff_timer #(
  parameter int HOLDOFF = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(HOLDOFF + 1);

  logic [CW-1:0] r_cnt;

  assign done = en && !clr && (r_cnt == CW'(HOLDOFF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || done) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scope_seq.sv
// Arm/trigger/capture/show sequencer and RAM address arbiter for the sample RAM.
// Optional circular pre-trigger capture is enabled by defining SCOPE_PRETRIG_EN.
module scope_seq
  import scope_pkg::*;
#(
  parameter int DEPTH       = SCOPE_DEPTH,
  parameter int AW          = SCOPE_AW,
`ifdef SCOPE_PRETRIG_EN
  parameter int PRE_SAMPLES = 64,
`endif
  parameter int HOLDOFF     = SCOPE_HOLDOFF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic          single,
  input  logic          trig,
  input  logic          smp_valid,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_adr,
  output logic [AW-1:0] ram_adr,
  output logic          ram_wren,
  output logic          rd_gnt,
  output logic          rst_trig,
  output logic          cap_done,
  output logic          busy,
  output logic [AW-1:0] trig_adr
);

  scope_state_t  r_state, w_state_next;
  logic [AW-1:0] r_wr_cnt, w_wr_cnt_next, w_wr_inc;
  logic          r_rst_trig, r_cap_done;
  logic          w_hold_clr, w_hold_en, w_hold_done;
  logic          w_writer_owns, w_trig_ok, w_wr_last;

  assign w_wr_inc = (r_wr_cnt == AW'(DEPTH - 1)) ? '0 : r_wr_cnt + 1'b1;

`ifdef SCOPE_PRETRIG_EN
  localparam int FW = $clog2(PRE_SAMPLES + 1);

  logic [FW-1:0] r_fill;
  logic [AW-1:0] r_rem, r_trig_adr;

  // ARMED already streams samples into the ring, so the writer owns the bus there too.
  assign w_writer_owns = (r_state == ARMED) || (r_state == CAPTURE);
  assign w_trig_ok     = trig && (r_fill == FW'(PRE_SAMPLES));
  assign w_wr_last     = (r_rem == AW'(1));
  assign trig_adr      = r_trig_adr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill     <= '0;
      r_rem      <= '0;
      r_trig_adr <= '0;
    end else begin
      if (r_state != ARMED) begin
        r_fill <= '0;
      end else if (smp_valid && (r_fill != FW'(PRE_SAMPLES))) begin
        r_fill <= r_fill + 1'b1;
      end

      if ((r_state == ARMED) && w_trig_ok) begin
        r_trig_adr <= r_wr_cnt;
        r_rem      <= AW'(DEPTH - PRE_SAMPLES);
      end else if ((r_state == CAPTURE) && smp_valid) begin
        r_rem <= r_rem - 1'b1;
      end
    end
  end
`else
  assign w_writer_owns = (r_state == CAPTURE);
  assign w_trig_ok     = trig;
  assign w_wr_last     = (r_wr_cnt == AW'(DEPTH - 1));
  assign trig_adr      = '0;
`endif

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (arm)                      w_state_next = ARMED;
      ARMED:   if (w_trig_ok)                w_state_next = CAPTURE;
      CAPTURE: if (smp_valid && w_wr_last)   w_state_next = SHOW;
      SHOW:    if (arm || w_hold_done)       w_state_next = ARMED;
      default:                               w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_wr_cnt_next = r_wr_cnt;
    if ((w_state_next == ARMED) && (r_state != ARMED)) begin
      w_wr_cnt_next = '0;
    end else if (r_state == ARMED) begin
`ifdef SCOPE_PRETRIG_EN
      if (smp_valid) w_wr_cnt_next = w_wr_inc;
`else
      if (w_trig_ok) w_wr_cnt_next = '0;
`endif
    end else if ((r_state == CAPTURE) && smp_valid) begin
      w_wr_cnt_next = w_wr_last ? '0 : w_wr_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wr_cnt   <= '0;
      r_rst_trig <= 1'b0;
      r_cap_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_cnt   <= w_wr_cnt_next;
      r_rst_trig <= (w_state_next == ARMED) && (r_state != ARMED);
      r_cap_done <= (r_state == CAPTURE) && (w_state_next == SHOW);
    end
  end

  assign w_hold_en  = (r_state == SHOW) && !single;
  assign w_hold_clr = (r_state != SHOW) || arm;

  holdoff_timer #(
    .HOLDOFF(HOLDOFF)
  ) u_holdoff (
    .clk (clk),
    .rst (rst),
    .clr (w_hold_clr),
    .en  (w_hold_en),
    .done(w_hold_done)
  );

  // Address and grant are gated by rst so every output reads zero during reset.
  assign ram_wren = w_writer_owns && smp_valid;
  assign ram_adr  = rst ? '0 : (w_writer_owns ? r_wr_cnt : rd_adr);
  assign rd_gnt   = !rst && !w_writer_owns && rd_req;
  assign busy     = is_busy(r_state);
  assign rst_trig = r_rst_trig;
  assign cap_done = r_cap_done;

endmodule

// File: tb/tb_scope_seq.sv
// Directed bench for scope_seq; expected write addresses go into a queue popped by a write monitor.
module tb_scope_seq;

  localparam int DEPTH = 640;
  localparam int AW    = 10;

  logic          clk = 1'b0;
  logic          rst, arm, single, trig, smp_valid, rd_req;
  logic [AW-1:0] rd_adr;
  logic [AW-1:0] ram_adr, trig_adr;
  logic          ram_wren, rd_gnt, rst_trig, cap_done, busy;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_rst_trig = 0;
  int n_cap_done = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  scope_seq #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .HOLDOFF(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .single   (single),
    .trig     (trig),
    .smp_valid(smp_valid),
    .rd_req   (rd_req),
    .rd_adr   (rd_adr),
    .ram_adr  (ram_adr),
    .ram_wren (ram_wren),
    .rd_gnt   (rd_gnt),
    .rst_trig (rst_trig),
    .cap_done (cap_done),
    .busy     (busy),
    .trig_adr (trig_adr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back((lo + k) % DEPTH);
  endtask

  // Write monitor: every RAM write must match the next expected address.
  always @(negedge clk) begin
    if (rst_trig) n_rst_trig++;
    if (cap_done) n_cap_done++;
    if (ram_wren) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected: write at address %0d, expected no write", ram_adr);
      end else begin
        chk("wr_adr", 32'(ram_adr), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; arm = 1'b0; single = 1'b1; trig = 1'b0; smp_valid = 1'b0;
    rd_req = 1'b1; rd_adr = 10'd100;
    tick(); tick();
    chk("rst_ram_adr", 32'(ram_adr), 0);
    chk("rst_ram_wren", 32'(ram_wren), 0);
    chk("rst_rd_gnt", 32'(rd_gnt), 0);
    chk("rst_rst_trig", 32'(rst_trig), 0);
    chk("rst_cap_done", 32'(cap_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_trig_adr", 32'(trig_adr), 0);
    rst = 1'b0;
    tick();
    $display("reset phase done");

`ifdef SCOPE_PRETRIG_EN
    arm = 1'b1; tick(); arm = 1'b0;
    chk("pt_armed_busy", 32'(busy), 1);
    chk("pt_armed_rd_gnt", 32'(rd_gnt), 0);
    push_range(0, 10);
    smp_valid = 1'b1; repeat (10) tick(); smp_valid = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    chk("pt_early_trig_adr", 32'(trig_adr), 0);
    $display("pretrig: trig at fill=10 issued");
    push_range(10, 690);
    smp_valid = 1'b1; repeat (690) tick(); smp_valid = 1'b0;
    chk("pt_wr_cnt_60", 32'(ram_adr), 60);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("pt_trig_adr", 32'(trig_adr), 60);
    push_range(60, 576);
    smp_valid = 1'b1;
    for (int i = 0; i < 576; i++) begin
      if (i == 575) chk("pt_busy_before_last", 32'(busy), 1);
      tick();
    end
    smp_valid = 1'b0;
    chk("pt_cap_done", 32'(cap_done), 1);
    chk("pt_show_busy", 32'(busy), 0);
    chk("pt_show_rd_gnt", 32'(rd_gnt), 1);
    tick();
    chk("pt_q_empty", 32'(exp_q.size()), 0);
    chk("pt_n_cap_done", 32'(n_cap_done), 1);
    $display("pretrig: capture of 576 post-trigger samples done");
`else
    chk("idle_rd_gnt", 32'(rd_gnt), 1);
    chk("idle_ram_adr", 32'(ram_adr), 100);

    // Capture 1: contiguous samples with a display read held throughout.
    arm = 1'b1; tick(); arm = 1'b0;
    chk("arm_rst_trig", 32'(rst_trig), 1);
    chk("arm_busy", 32'(busy), 1);
    chk("armed_rd_gnt", 32'(rd_gnt), 1);
    chk("armed_wren", 32'(ram_wren), 0);
    tick();
    chk("rst_trig_one_cycle", 32'(rst_trig), 0);
    trig = 1'b1; tick(); trig = 1'b0;
    chk("cap_rd_gnt", 32'(rd_gnt), 0);
    chk("cap_first_adr", 32'(ram_adr), 0);
    push_range(0, DEPTH);
    smp_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 320) begin
        chk("cap_mid_rd_gnt", 32'(rd_gnt), 0);
        chk("cap_mid_adr", 32'(ram_adr), 320);
      end
      tick();
    end
    smp_valid = 1'b0;
    chk("c1_cap_done", 32'(cap_done), 1);
    chk("c1_show_busy", 32'(busy), 0);
    chk("c1_show_rd_gnt", 32'(rd_gnt), 1);
    chk("c1_show_adr", 32'(ram_adr), 100);
    tick();
    chk("c1_cap_done_low", 32'(cap_done), 0);
    chk("c1_n_cap_done", 32'(n_cap_done), 1);
    chk("c1_n_rst_trig", 32'(n_rst_trig), 1);
    chk("c1_q_empty", 32'(exp_q.size()), 0);
    $display("capture 1: 640 contiguous writes done");

    // Single-shot: remain in SHOW until arm.
    repeat (100) tick();
    chk("single_busy", 32'(busy), 0);
    chk("single_no_rearm", 32'(n_rst_trig), 1);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("single_arm_busy", 32'(busy), 1);
    chk("single_arm_rst_trig", 32'(rst_trig), 1);
    $display("single-shot: held 100 cycles then re-armed");

    // Capture 2: samples valid every other cycle, auto re-arm afterwards.
    single = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    push_range(0, DEPTH);
    for (int i = 0; i < 2 * DEPTH; i++) begin
      smp_valid = (i % 2 == 1);
      if (i == 2 * DEPTH - 1) begin
        chk("c2_busy_last", 32'(busy), 1);
        chk("c2_no_early_done", 32'(cap_done), 0);
      end
      tick();
    end
    smp_valid = 1'b0;
    chk("c2_cap_done", 32'(cap_done), 1);
    chk("c2_show_busy", 32'(busy), 0);
    chk("c2_q_empty", 32'(exp_q.size()), 0);
    $display("capture 2: 640 writes over 1280 cycles done");

    repeat (7) tick();
    chk("holdoff_still_show", 32'(busy), 0);
    chk("holdoff_no_rst_trig", 32'(rst_trig), 0);
    tick();
    chk("holdoff_rearm_busy", 32'(busy), 1);
    chk("holdoff_rst_trig", 32'(rst_trig), 1);
    $display("holdoff: re-armed 8 cycles after SHOW entry");

    // Reset in the middle of a capture.
    single = 1'b1;
    trig = 1'b1; tick(); trig = 1'b0;
    push_range(0, 300);
    smp_valid = 1'b1;
    repeat (300) tick();
    chk("mid_wr_cnt", 32'(ram_adr), 300);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_wren", 32'(ram_wren), 0);
    chk("mid_rst_adr", 32'(ram_adr), 0);
    chk("mid_rst_rd_gnt", 32'(rd_gnt), 0);
    chk("mid_rst_cap_done", 32'(cap_done), 0);
    smp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mid_no_cap_done", 32'(n_cap_done), 2);
    chk("mid_q_empty", 32'(exp_q.size()), 0);
    $display("reset at wr_cnt=300 done");

    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    chk("restart_adr", 32'(ram_adr), 0);
    push_range(0, DEPTH);
    smp_valid = 1'b1; repeat (DEPTH) tick(); smp_valid = 1'b0;
    chk("c3_cap_done", 32'(cap_done), 1);
    tick();
    chk("c3_n_cap_done", 32'(n_cap_done), 3);
    chk("c3_n_rst_trig", 32'(n_rst_trig), 4);
    chk("c3_q_empty", 32'(exp_q.size()), 0);
    $display("capture 3: restart from address 0 done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scope_seq.md
Name: scope_seq

Overview:
- Sequencer and arbiter for the single-port 640-word sample RAM of the capture path.
- Runs the arm → trigger → capture → display cycle and generates the write addresses and write enable.
- Shares the RAM address bus between the capture writer and the display reader, with the writer having absolute priority.
- Sits between the trigger detector, the sample source and the VGA display read port.

Parameters:
- DEPTH, 640: number of RAM words per capture.
- AW, 10: RAM address width; must satisfy 2^AW >= DEPTH.
- HOLDOFF, 1000: clk cycles spent in SHOW before auto re-arm.
- PRE_SAMPLES, 64: pre-trigger depth; used only with SCOPE_PRETRIG_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- arm  in  1  one-cycle arm request.
- single  in  1  1 = single-shot mode, 0 = auto re-arm.
- trig  in  1  trigger event from the trigger detector.
- smp_valid  in  1  a new sample is present on the RAM data bus this cycle.
- rd_req  in  1  display read request.
- rd_adr  in  AW  display read address.
- ram_adr  out  AW  RAM address.
- ram_wren  out  1  RAM write enable.
- rd_gnt  out  1  display read granted this cycle.
- rst_trig  out  1  one-cycle pulse that clears the trigger detector.
- cap_done  out  1  one-cycle pulse when a capture completes.
- busy  out  1  high in ARMED and CAPTURE.
- trig_adr  out  AW  RAM address of the trigger sample.

Behaviour:
- State register is 2 bits: IDLE=0, ARMED=1, CAPTURE=2, SHOW=3. Write counter wr_cnt is AW bits.
- Holdoff counter is clog2(HOLDOFF+1) bits.
- Reset (asynchronous):
  - state=IDLE; wr_cnt=0; holdoff counter=0; trig_adr=0.
  - rst_trig=0, cap_done=0.
  - All outputs are low/zero while rst is high.
- IDLE:
  - arm=1 → ARMED, with rst_trig=1 for one cycle (registered, asserted in the first ARMED cycle).
  - trig is ignored.
- ARMED:
  - trig=1 → CAPTURE, wr_cnt←0.
  - arm is ignored.
- CAPTURE:
  - ram_wren = smp_valid. ram_adr = wr_cnt. wr_cnt increments on each valid sample.
  - A valid sample with wr_cnt==DEPTH-1 is the last write. Next state is SHOW, wr_cnt←0, and cap_done=1 in the first SHOW cycle.
  - Cycles with smp_valid=0 hold wr_cnt; no write occurs.
  - arm and trig are ignored.
- SHOW:
  - single=1: stay in SHOW until arm=1, then → ARMED with a rst_trig pulse.
  - single=0: the holdoff counter counts from 0. When it reaches HOLDOFF-1 → ARMED with a rst_trig pulse, counter←0.
  - arm=1 in SHOW → ARMED immediately, in either mode; the holdoff counter clears.
- Arbitration (combinational from registered state):
  - In CAPTURE: ram_adr=wr_cnt, rd_gnt=0.
  - In all other states: ram_adr=rd_adr, rd_gnt=rd_req, ram_wren=0.
  - rd_adr >= DEPTH is passed through unchanged; range checking is the display's responsibility.
  - Display reads in ARMED are granted; the data returned is the previous capture.
- busy = (state==ARMED)|(state==CAPTURE).
- wr_cnt never exceeds DEPTH-1.
- Reset during CAPTURE: return to IDLE. No cap_done is produced and the RAM contents are undefined.

Optional Feature:
- Macro SCOPE_PRETRIG_EN.
- With the macro defined:
  - ARMED writes every valid sample circularly at wr_cnt, wrapping DEPTH-1 → 0. wr_cnt clears on entry to ARMED.
  - A fill counter saturates at PRE_SAMPLES. trig is accepted only when fill==PRE_SAMPLES.
  - On an accepted trig: trig_adr←wr_cnt and rem←DEPTH-PRE_SAMPLES.
  - In CAPTURE, wr_cnt continues circularly and rem decrements per valid write. The write with rem==1 ends the capture → SHOW.
  - Display reads do not get the bus in ARMED in this mode (rd_gnt=0).
- Without the macro: ARMED never writes, trig_adr stays 0, and CAPTURE fills addresses 0..DEPTH-1.

Decomposition:
- Package scope_pkg: state encodings IDLE, ARMED, CAPTURE, SHOW; DEPTH and AW defaults.
- Sub-module holdoff_timer: parameter HOLDOFF; inputs clk, rst, clr, en; output done.
- All other logic stays in scope_seq.

Test Plan:
- Reset, then arm pulse, then trig, then 640 consecutive smp_valid. Required:
  - ram_adr steps 0..639 with ram_wren=1.
  - State is SHOW after the 640th write; cap_done is high for exactly one cycle.
  - rst_trig pulsed once, one cycle after arm.
- Capture with smp_valid toggling every other cycle. Required: exactly 640 writes with no skipped or repeated addresses, and completion after 1280 cycles.
- rd_req=1, rd_adr=100 held throughout a capture. Required:
  - rd_gnt=0 and ram_adr=wr_cnt during CAPTURE.
  - In SHOW: rd_gnt=1 and ram_adr=100.
- single=0, HOLDOFF=8. Required: ARMED re-entered exactly 8 cycles after entry to SHOW, with a rst_trig pulse. With single=1: stays in SHOW for 100 cycles, then leaves on arm.
- rst asserted at wr_cnt=300. Required:
  - Immediate IDLE, all outputs 0, no cap_done.
  - After the next arm+trig, writes restart at address 0.
- SCOPE_PRETRIG_EN, PRE_SAMPLES=64. Required:
  - trig at fill=10 is ignored.
  - trig accepted with wr_cnt=700 mod 640 = 60 sets trig_adr=60.
  - Capture ends after 576 further writes.
